// File: rtl/super_mac_ctrl.sv
// rtl/super_mac_ctrl.sv - fetch/MAC sequencer for the 16-lane super_mac array.
// Optional SUPER_MAC_CTRL_PERF_EN adds perf_cycles/perf_stalls counters.
module super_mac_ctrl #(
  parameter int TERM_W      = 16,
  parameter int OUT_W       = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              arst_in,
  input  logic              start,
  input  logic [TERM_W-1:0] cfg_terms,
  input  logic [OUT_W-1:0]  cfg_outputs,
  input  logic              fetch_stall,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [TERM_W-1:0] term_idx,
  output logic [OUT_W-1:0]  out_idx,
  output logic              mac_input_valid,
  output logic              mac_accumulate_internal,
  output logic              out_write,
`ifdef SUPER_MAC_CTRL_PERF_EN
  output logic [OUT_W-1:0]  out_addr,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`else
  output logic [OUT_W-1:0]  out_addr
`endif
);

  localparam logic [TERM_W-1:0] TERM_ONE = 1;
  localparam logic [OUT_W-1:0]  OUT_ONE  = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [TERM_W-1:0] terms_q;
  logic [OUT_W-1:0]  outs_q;
  logic              cfg_ok;
  logic              term_last;
  logic              pix_last;
  logic              job_start;
  logic              final_write;

  logic [MEM_LATENCY-1:0] dl_valid;
  logic [MEM_LATENCY-1:0] dl_first;
  logic [MEM_LATENCY-1:0] dl_last;
  logic [OUT_W-1:0]       dl_idx [MEM_LATENCY];

  assign cfg_ok      = (cfg_terms != '0) && (cfg_outputs != '0);
  assign job_start   = (state == IDLE) && start;
  assign term_last   = (term_idx == terms_q - TERM_ONE);
  assign pix_last    = (out_idx == outs_q - OUT_ONE);
  assign final_write = out_write && (out_addr == outs_q - OUT_ONE);

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = cfg_ok ? RUN : DONE;
      RUN:     if (rd_en && term_last && pix_last) state_nxt = DRAIN;
      DRAIN:   if (final_write) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    rd_en = (state == RUN) && !fetch_stall;
  end

  // Counters clear on the job's final fetch so they never step past cfg-1.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      terms_q  <= '0;
      outs_q   <= '0;
      term_idx <= '0;
      out_idx  <= '0;
    end else if (job_start && cfg_ok) begin
      terms_q  <= cfg_terms;
      outs_q   <= cfg_outputs;
      term_idx <= '0;
      out_idx  <= '0;
    end else if (rd_en) begin
      if (term_last) begin
        term_idx <= '0;
        out_idx  <= pix_last ? '0 : out_idx + OUT_ONE;
      end else begin
        term_idx <= term_idx + TERM_ONE;
      end
    end
  end

  // Delay line aligns fetch tags with data arriving from memory.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      dl_valid <= '0;
      dl_first <= '0;
      dl_last  <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) dl_idx[i] <= '0;
    end else begin
      dl_valid[0] <= rd_en;
      dl_first[0] <= rd_en && (term_idx == '0);
      dl_last[0]  <= rd_en && term_last;
      dl_idx[0]   <= rd_en ? out_idx : '0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_first[i] <= dl_first[i-1];
        dl_last[i]  <= dl_last[i-1];
        dl_idx[i]   <= dl_idx[i-1];
      end
    end
  end

  assign mac_input_valid         = dl_valid[MEM_LATENCY-1];
  assign mac_accumulate_internal = dl_valid[MEM_LATENCY-1] && !dl_first[MEM_LATENCY-1];

  // One extra stage matches the super_mac output register.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      out_write <= 1'b0;
      out_addr  <= '0;
    end else begin
      out_write <= dl_valid[MEM_LATENCY-1] && dl_last[MEM_LATENCY-1];
      if (dl_valid[MEM_LATENCY-1] && dl_last[MEM_LATENCY-1])
        out_addr <= dl_idx[MEM_LATENCY-1];
    end
  end

`ifdef SUPER_MAC_CTRL_PERF_EN
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (job_start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && perf_cycles != '1)
        perf_cycles <= perf_cycles + 32'd1;
      if (state == RUN && fetch_stall && perf_stalls != '1)
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_super_mac_ctrl.sv
// tb/tb_super_mac_ctrl.sv - directed self-checking bench for super_mac_ctrl.
module tb_super_mac_ctrl;

  logic        clk = 1'b0;
  logic        arst_in;
  logic        start;
  logic [15:0] cfg_terms;
  logic [15:0] cfg_outputs;
  logic        fetch_stall;

  logic        busy, done, rd_en, mac_input_valid, mac_accumulate_internal, out_write;
  logic [15:0] term_idx, out_idx, out_addr;
  logic        busy3, done3, rd_en3, val3, acc3, ow3;
  logic [15:0] term_idx3, out_idx3, out_addr3;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_rd, m_val, m_acc, m_ow, m_done, m_busy, m_val3, m_ow3;
  logic [15:0] addrs [8];
  logic [15:0] tidx [32];
  int          n_ow;
  logic        rst_all_zero;

  always #5 clk = ~clk;

  super_mac_ctrl #(.TERM_W(16), .OUT_W(16), .MEM_LATENCY(1)) dut (
    .clk(clk), .arst_in(arst_in), .start(start), .cfg_terms(cfg_terms),
    .cfg_outputs(cfg_outputs), .fetch_stall(fetch_stall), .busy(busy), .done(done),
    .rd_en(rd_en), .term_idx(term_idx), .out_idx(out_idx),
    .mac_input_valid(mac_input_valid), .mac_accumulate_internal(mac_accumulate_internal),
    .out_write(out_write), .out_addr(out_addr)
  );

  super_mac_ctrl #(.TERM_W(16), .OUT_W(16), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .arst_in(arst_in), .start(start), .cfg_terms(cfg_terms),
    .cfg_outputs(cfg_outputs), .fetch_stall(fetch_stall), .busy(busy3), .done(done3),
    .rd_en(rd_en3), .term_idx(term_idx3), .out_idx(out_idx3),
    .mac_input_valid(val3), .mac_accumulate_internal(acc3),
    .out_write(ow3), .out_addr(out_addr3)
  );

  // Called at a negedge; cycle c is the period ending at the following posedge.
  task automatic run_job(input int terms, input int outs, input int stall_lo,
                         input int stall_hi, input int start2, input int rst_cyc);
    m_rd = '0; m_val = '0; m_acc = '0; m_ow = '0; m_done = '0; m_busy = '0;
    m_val3 = '0; m_ow3 = '0; n_ow = 0; rst_all_zero = 1'b0;
    cfg_terms = 16'(terms);
    cfg_outputs = 16'(outs);
    for (int c = 0; c < 32; c++) begin
      start = (c == 0) || (c == start2);
      fetch_stall = (c >= stall_lo) && (c <= stall_hi);
      if (c == rst_cyc) arst_in = 1'b1;
      if (c == rst_cyc + 1) arst_in = 1'b0;
      #1;
      m_rd[c] = rd_en;  m_val[c] = mac_input_valid;  m_acc[c] = mac_accumulate_internal;
      m_ow[c] = out_write;  m_done[c] = done;  m_busy[c] = busy;
      m_val3[c] = val3;  m_ow3[c] = ow3;
      tidx[c] = term_idx;
      if (out_write && n_ow < 8) begin
        addrs[n_ow] = out_addr;
        n_ow++;
      end
      if (c == rst_cyc)
        rst_all_zero = !(busy | done | rd_en | mac_input_valid | mac_accumulate_internal |
                         out_write) && term_idx == 0 && out_idx == 0 && out_addr == 0;
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    fetch_stall = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({busy, done, rd_en, mac_input_valid, mac_accumulate_internal, out_write} !== 6'b0 ||
        term_idx !== 16'd0 || out_idx !== 16'd0 || out_addr !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b rd=%b ow=%b required all 0",
               busy, done, rd_en, out_write);
    end
  endtask

  task automatic test_basic;
    run_job(4, 2, -1, -1, -1, -1);
    total++; if (m_rd !== 32'h1FE)   begin bad++; $display("FAIL basic_rd_en: got %h want %h", m_rd, 32'h1FE); end
    total++; if (m_val !== 32'h3FC)  begin bad++; $display("FAIL basic_valid: got %h want %h", m_val, 32'h3FC); end
    total++; if (m_acc !== 32'h3B8)  begin bad++; $display("FAIL basic_accum: got %h want %h", m_acc, 32'h3B8); end
    total++; if (m_ow !== 32'h440)   begin bad++; $display("FAIL basic_out_write: got %h want %h", m_ow, 32'h440); end
    total++; if (m_done !== 32'h800) begin bad++; $display("FAIL basic_done: got %h want %h", m_done, 32'h800); end
    total++; if (m_busy !== 32'hFFE) begin bad++; $display("FAIL basic_busy: got %h want %h", m_busy, 32'hFFE); end
    total++; if (n_ow != 2 || addrs[0] !== 16'd0 || addrs[1] !== 16'd1) begin
      bad++; $display("FAIL basic_out_addr: n=%0d a0=%0d a1=%0d want n=2 a0=0 a1=1", n_ow, addrs[0], addrs[1]);
    end
    total++; if (m_val3 !== 32'hFF0)  begin bad++; $display("FAIL lat3_valid: got %h want %h", m_val3, 32'hFF0); end
    total++; if (m_ow3 !== 32'h1100)  begin bad++; $display("FAIL lat3_out_write: got %h want %h", m_ow3, 32'h1100); end
  endtask

  task automatic test_stall;
    run_job(4, 2, 3, 4, -1, -1);
    total++; if (m_rd !== 32'h7E6)    begin bad++; $display("FAIL stall_rd_en: got %h want %h", m_rd, 32'h7E6); end
    total++; if (tidx[3] !== 16'd2 || tidx[4] !== 16'd2) begin
      bad++; $display("FAIL stall_term_hold: got %0d,%0d want 2,2", tidx[3], tidx[4]);
    end
    total++; if (m_val !== 32'hFCC)   begin bad++; $display("FAIL stall_valid: got %h want %h", m_val, 32'hFCC); end
    total++; if (m_acc !== 32'hEC8)   begin bad++; $display("FAIL stall_accum: got %h want %h", m_acc, 32'hEC8); end
    total++; if (m_ow !== 32'h1100)   begin bad++; $display("FAIL stall_out_write: got %h want %h", m_ow, 32'h1100); end
    total++; if (m_done !== 32'h2000) begin bad++; $display("FAIL stall_done: got %h want %h", m_done, 32'h2000); end
    total++; if (m_busy !== 32'h3FFE) begin bad++; $display("FAIL stall_busy: got %h want %h", m_busy, 32'h3FFE); end
  endtask

  task automatic test_single_term;
    run_job(1, 3, -1, -1, -1, -1);
    total++; if (m_rd !== 32'hE)   begin bad++; $display("FAIL single_rd_en: got %h want %h", m_rd, 32'hE); end
    total++; if (m_acc !== 32'h0)  begin bad++; $display("FAIL single_accum: got %h want 0", m_acc); end
    total++; if (m_ow !== 32'h38)  begin bad++; $display("FAIL single_out_write: got %h want %h", m_ow, 32'h38); end
    total++; if (n_ow != 3 || addrs[0] !== 16'd0 || addrs[1] !== 16'd1 || addrs[2] !== 16'd2) begin
      bad++; $display("FAIL single_out_addr: n=%0d a=%0d,%0d,%0d want 3 a=0,1,2", n_ow, addrs[0], addrs[1], addrs[2]);
    end
    total++; if (m_done !== 32'h40) begin bad++; $display("FAIL single_done: got %h want %h", m_done, 32'h40); end
  endtask

  task automatic test_zero_cfg;
    run_job(4, 0, -1, -1, 1, -1);
    total++; if (m_done !== 32'h2) begin bad++; $display("FAIL zero_done: got %h want %h", m_done, 32'h2); end
    total++; if (m_rd !== 32'h0 || m_ow !== 32'h0) begin
      bad++; $display("FAIL zero_no_fetch: rd=%h ow=%h want 0,0", m_rd, m_ow);
    end
    total++; if (m_busy !== 32'h2) begin bad++; $display("FAIL zero_start_ignored: busy=%h want %h", m_busy, 32'h2); end
  endtask

  task automatic test_reset_mid_job;
    run_job(4, 2, -1, -1, -1, 5);
    total++; if (rst_all_zero !== 1'b1) begin bad++; $display("FAIL midrst_outputs: got %b want 1", rst_all_zero); end
    total++; if (m_done !== 32'h0)  begin bad++; $display("FAIL midrst_no_done: got %h want 0", m_done); end
    total++; if (m_busy !== 32'h1E) begin bad++; $display("FAIL midrst_busy: got %h want %h", m_busy, 32'h1E); end
    total++; if (m_ow !== 32'h0)    begin bad++; $display("FAIL midrst_no_write: got %h want 0", m_ow); end
  endtask

  initial begin
    arst_in = 1'b1;
    start = 1'b0;
    cfg_terms = '0;
    cfg_outputs = '0;
    fetch_stall = 1'b0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    arst_in = 1'b0;
    @(negedge clk);
    test_basic();
    test_stall();
    test_single_term();
    test_zero_cfg();
    test_reset_mid_job();
    test_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/super_mac_ctrl.md
Name: super_mac_ctrl

Overview:
Sequencer for the 16-lane super_mac array. Steps through one convolution job of cfg_outputs output pixels, each the sum of cfg_terms products. Issues feature/kernel fetch addresses and aligns the super_mac input_valid and accumulate_internal controls with the memory read latency. Flags when the 16 super_mac outputs hold a finished result for write-back.

Parameters:
TERM_W, 16, width of the term counter and cfg_terms
OUT_W, 16, width of the output-pixel counter and cfg_outputs
MEM_LATENCY, 1, cycles from rd_en to fetched a/b data at the super_mac inputs (legal range 1..4)

Ports:
clk  in  1  clock, all state on rising edge
arst_in  in  1  asynchronous reset, active-high
start  in  1  job request, sampled only in IDLE
cfg_terms  in  TERM_W  products per output pixel, latched at start
cfg_outputs  in  OUT_W  output pixels per job, latched at start
fetch_stall  in  1  fetch memory not ready; hold issue while high
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end
rd_en  out  1  fetch strobe for feature/kernel memories
term_idx  out  TERM_W  term address of current fetch
out_idx  out  OUT_W  pixel address of current fetch
mac_input_valid  out  1  drives super_mac input_valid
mac_accumulate_internal  out  1  drives super_mac accumulate_internal
out_write  out  1  super_mac outputs hold the finished pixel this cycle
out_addr  out  OUT_W  pixel index belonging to out_write

Behaviour:
- Reset (async assert, sync release): state IDLE, counters 0, delay line cleared. All outputs 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start when both cfg values are nonzero. Latch cfg and clear term_idx/out_idx.
- IDLE -> DONE on start when either cfg value is 0. No rd_en and no out_write are issued.
- start in any other state is ignored.
- RUN: rd_en = ~fetch_stall. On each issued fetch, term_idx increments.
  - At term_idx = cfg_terms-1, term_idx wraps to 0 and out_idx increments.
  - The fetch of the last term of the last pixel moves the FSM to DRAIN.
  - While fetch_stall is high, counters hold and a bubble enters the delay line.
- Delay line: MEM_LATENCY stages, each holding {valid, first, last, out_idx}.
  - Head drives mac_input_valid = valid.
  - Head drives mac_accumulate_internal = valid & ~first. The first term loads, later terms accumulate.
  - accumulate_internal is 0 whenever valid is 0.
- out_write: one cycle after the head presents valid & last, registered to match the super_mac output register. out_addr is that entry's out_idx.
- DRAIN: lasts until the final out_write has issued, then the FSM moves to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: a term fetched at cycle t reaches the MAC at t+MEM_LATENCY. Its pixel's out_write occurs at t_last+MEM_LATENCY+1.
- cfg_terms = 1: every term is both first and last. One out_write per fetch.
- Counters never exceed cfg-1. No wrap beyond the job.
- Reset mid-job: immediate abort to IDLE. Delay line is flushed, no done pulse.

Optional Feature:
SUPER_MAC_CTRL_PERF_EN
- Defined: adds outputs perf_cycles[31:0] and perf_stalls[31:0].
  - Both clear on job start.
  - perf_cycles counts cycles with busy high.
  - perf_stalls counts RUN cycles with fetch_stall high.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- MEM_LATENCY=1, cfg_terms=4, cfg_outputs=2, start at cycle 0, no stall:
  - rd_en cycles 1-8.
  - mac_input_valid cycles 2-9.
  - mac_accumulate_internal low at cycles 2 and 6 only.
  - out_write at cycles 6 (addr 0) and 10 (addr 1).
  - done at cycle 11, busy 1-11.
- Same job with fetch_stall high at cycles 3-4:
  - No rd_en at cycles 3-4, term_idx holds 2.
  - Bubbles appear at mac_input_valid cycles 4-5.
  - out_write at cycles 8 and 12, done at cycle 13.
- cfg_terms=1, cfg_outputs=3:
  - Accumulate_internal is never high.
  - out_write at cycles 3, 4, 5 with addr 0, 1, 2.
- cfg_outputs=0 with start: done at cycle 1, no rd_en, no out_write. A start pulse at cycle 1 is ignored.
- arst_in pulsed at cycle 5 of the first job: all outputs 0 immediately, no done. A new start afterwards runs the full job correctly.
- MEM_LATENCY=3 with the first job: mac_input_valid cycles 4-11, out_write at cycles 8 and 12.
